// File: rtl/rng_reader_if.sv
// rtl/rng_reader_if.sv - command, output stream and peripheral register bundle for rng_reader
//
// Purpose: groups every non-clock/reset signal of rng_reader.
//   master : the rng_reader side (drives cmd_ready, out_*, status and reg_* requests)
//   slave  : the environment side (command source, word consumer, LFSR peripheral)
// Signals:
//   cmd_valid/cmd_ready/cmd_seed_en/cmd_seed/cmd_count : command handshake
//   out_valid/out_ready/out_data                       : buffered word stream
//   busy/err_timeout/err_seed                          : status
//   reg_seed_we/reg_seed_di/reg_seed_do                : seed register
//   reg_dat_we/reg_dat_re/reg_dat_di/reg_dat_do/reg_dat_wait : data register

interface rng_reader_if #(
  parameter int COUNT_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_seed_en;
  logic [31:0]        cmd_seed;
  logic [COUNT_W-1:0] cmd_count;

  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;

  logic               busy;
  logic               err_timeout;
  logic               err_seed;

  logic [3:0]         reg_seed_we;
  logic [31:0]        reg_seed_di;
  logic [31:0]        reg_seed_do;
  logic               reg_dat_we;
  logic               reg_dat_re;
  logic [31:0]        reg_dat_di;
  logic [31:0]        reg_dat_do;
  logic               reg_dat_wait;

  modport master (
    input  cmd_valid, cmd_seed_en, cmd_seed, cmd_count, out_ready,
           reg_seed_do, reg_dat_do, reg_dat_wait,
    output cmd_ready, out_valid, out_data, busy, err_timeout, err_seed,
           reg_seed_we, reg_seed_di, reg_dat_we, reg_dat_re, reg_dat_di
  );

  modport slave (
    output cmd_valid, cmd_seed_en, cmd_seed, cmd_count, out_ready,
           reg_seed_do, reg_dat_do, reg_dat_wait,
    input  cmd_ready, out_valid, out_data, busy, err_timeout, err_seed,
           reg_seed_we, reg_seed_di, reg_dat_we, reg_dat_re, reg_dat_di
  );
endinterface

// File: rtl/rng_reader.sv
// rtl/rng_reader.sv - bus initiator that seeds and reads an LFSR peripheral into a FWFT FIFO
//
// Purpose: accepts {seed_en, seed, count}, optionally writes and verifies the seed,
//   then issues one reg_dat_re per word, waits out reg_dat_wait (with timeout) and
//   buffers returned words for the consumer.
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : rng_reader_if.master (command, output stream, status, peripheral registers)

module rng_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int COUNT_W    = 8,
  parameter int TIMEOUT    = 255
) (
  input logic         clk,
  input logic         resetn,
  rng_reader_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED_WR,
    S_SEED_SETTLE,
    S_SEED_CHK,
    S_RD_REQ,
    S_RD_GAP,
    S_RD_WAIT
  } state_t;

  state_t             r_state;
  logic [31:0]        r_seed;
  logic [COUNT_W-1:0] r_count;
  logic [TW-1:0]      r_tmo;       // settle counter in SEED_SETTLE, wait counter in RD_WAIT
  logic [3:0]         r_seed_we;
  logic [31:0]        r_seed_di;
  logic               r_err_timeout;
  logic               r_err_seed;

  logic [31:0]        r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [PW:0]        r_fill;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_fill == (PW+1)'(FIFO_DEPTH));
  assign w_empty = (r_fill == '0);
  // A word is only ever requested when a slot is free, so a push never meets a full FIFO.
  assign w_push  = (r_state == S_RD_WAIT) && !bus.reg_dat_wait;
  assign w_pop   = !w_empty && bus.out_ready;

  assign bus.cmd_ready   = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_seed    = r_err_seed;
  assign bus.reg_seed_we = r_seed_we;
  assign bus.reg_seed_di = r_seed_di;
  assign bus.reg_dat_we  = 1'b0;
  assign bus.reg_dat_di  = '0;
  // Decoded from registers only; being in RD_REQ with room is exactly one cycle.
  assign bus.reg_dat_re  = (r_state == S_RD_REQ) && !w_full;
  assign bus.out_valid   = !w_empty;
  assign bus.out_data    = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_seed        <= '0;
      r_count       <= '0;
      r_tmo         <= '0;
      r_seed_we     <= '0;
      r_seed_di     <= '0;
      r_err_timeout <= 1'b0;
      r_err_seed    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_seed        <= bus.cmd_seed;
            r_count       <= bus.cmd_count;
            r_err_timeout <= 1'b0;
            r_err_seed    <= 1'b0;
            if (bus.cmd_seed_en) begin
              r_seed_we <= 4'hF;
              r_seed_di <= bus.cmd_seed;
              r_state   <= S_SEED_WR;
            end else if (bus.cmd_count != '0) begin
              r_state <= S_RD_REQ;
            end
          end
        end
        S_SEED_WR: begin
          r_seed_we <= '0;
          r_tmo     <= '0;
          r_state   <= S_SEED_SETTLE;
        end
        S_SEED_SETTLE: begin
          // Two cycles for the peripheral to reload its LFSR before readback.
          if (r_tmo == TW'(1)) r_state <= S_SEED_CHK;
          else                 r_tmo   <= r_tmo + 1'b1;
        end
        S_SEED_CHK: begin
          if (bus.reg_seed_do != r_seed) begin
            r_err_seed <= 1'b1;
            r_state    <= S_IDLE;
          end else if (r_count == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (!w_full) r_state <= S_RD_GAP;
        end
        S_RD_GAP: begin
          // reg_dat_wait may still show the previous read's done here; ignore it.
          r_tmo   <= '0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (!bus.reg_dat_wait) begin
            r_count <= r_count - 1'b1;
            r_state <= (r_count == COUNT_W'(1)) ? S_IDLE : S_RD_REQ;
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.reg_dat_do;
  end

endmodule

// File: tb/tb_rng_reader.sv
// tb/tb_rng_reader.sv - self-checking bench for rng_reader with an LFSR peripheral model

module tb_rng_reader;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rng_reader_if #(.COUNT_W(8)) bus ();

  rng_reader #(.FIFO_DEPTH(4), .COUNT_W(8), .TIMEOUT(255)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- peripheral model ----------------
  logic [31:0] p_store = '0;
  logic [31:0] p_lfsr  = '0;
  logic [31:0] p_dat   = '0;
  logic        p_wait  = 1'b0;
  logic        p_pend  = 1'b0;
  int          p_cnt   = 0;
  logic        p_stuck = 1'b0;
  logic        p_fault = 1'b0;

  function automatic logic [31:0] p_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  assign bus.reg_seed_do  = (p_fault && p_store == 32'h1) ? 32'hDEADBEEF : p_store;
  assign bus.reg_dat_do   = p_dat;
  assign bus.reg_dat_wait = p_wait;

  always @(posedge clk) begin
    if (bus.reg_seed_we != 4'h0) begin
      p_store <= byte_merge(p_store, bus.reg_seed_di, bus.reg_seed_we);
      p_lfsr  <= byte_merge(p_store, bus.reg_seed_di, bus.reg_seed_we);
    end else if (bus.reg_dat_re) begin
      p_pend <= 1'b1;                    // wait rises one cycle late (stale done)
    end else if (p_pend) begin
      p_pend <= 1'b0;
      p_wait <= 1'b1;
      p_cnt  <= p_stuck ? 0 : 32;
    end else if (p_wait && !p_stuck) begin
      if (p_cnt == 0) begin
        p_wait <= 1'b0;
      end else begin
        p_lfsr <= p_step(p_lfsr);
        p_cnt  <= p_cnt - 1;
        if (p_cnt == 1) begin
          p_wait <= 1'b0;
          p_dat  <= p_step(p_lfsr);
        end
      end
    end
  end

  // ---------------- bus monitor ----------------
  int          re_cnt  = 0;
  int          we_cnt  = 0;
  logic [31:0] last_di = '0;
  always @(posedge clk) begin
    if (bus.reg_dat_re) re_cnt <= re_cnt + 1;
    if (bus.reg_seed_we == 4'hF) begin
      we_cnt  <= we_cnt + 1;
      last_di <= bus.reg_seed_di;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_state = '0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] next_word(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 32; i++) r = {r[30:0], ^(r & 32'h8020_0003)};
    return r;
  endfunction

  task automatic expect_words(input int n);
    for (int i = 0; i < n; i++) begin
      ref_state = next_word(ref_state);
      exp_q.push_back(ref_state);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic en, input logic [31:0] seed, input logic [7:0] cnt);
    int t;
    t = 0;
    while (!bus.cmd_ready && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) check("cmd_ready_timeout", 0, 1);
    bus.cmd_seed_en = en;
    bus.cmd_seed    = seed;
    bus.cmd_count   = cnt;
    bus.cmd_valid   = 1'b1;
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
    if (en) ref_state = seed;
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    while (bus.busy && t < bound) begin @(negedge clk); t++; end
    check("wait_idle_bound", bus.busy, 0);
  endtask

  task automatic pop_words(input string tag, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!bus.out_valid && t < 300) begin @(negedge clk); t++; end
      if (exp_q.size() == 0) check({tag, "_unexpected"}, 1, 0);
      else check(tag, bus.out_data, exp_q.pop_front());
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int re0, we0, t;
  logic [31:0] sd;
  logic        en;
  logic [7:0]  cn;

  initial begin
    bus.cmd_valid   = 1'b0;
    bus.cmd_seed_en = 1'b0;
    bus.cmd_seed    = '0;
    bus.cmd_count   = '0;
    bus.out_ready   = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_err_timeout", bus.err_timeout, 0);
    check("rst_err_seed", bus.err_seed, 0);
    check("rst_seed_we", bus.reg_seed_we, 0);
    check("rst_seed_di", bus.reg_seed_di, 0);
    check("rst_dat_re", bus.reg_dat_re, 0);
    check("dat_we_tied", bus.reg_dat_we, 0);
    check("dat_di_tied", bus.reg_dat_di, 0);
    resetn = 1'b1;
    @(negedge clk);

    // zero seed, three words of zero
    re0 = re_cnt; we0 = we_cnt;
    send_cmd(1'b1, 32'h0, 8'd3);
    expect_words(3);
    wait_idle(1000);
    check("t1_we_cycles", we_cnt - we0, 1);
    check("t1_seed_di", last_di, 32'h0);
    check("t1_re_pulses", re_cnt - re0, 3);
    check("t1_err_seed", bus.err_seed, 0);
    check("t1_err_timeout", bus.err_timeout, 0);
    pop_words("t1_word", 3);

    // known seed, four words against the model
    re0 = re_cnt;
    send_cmd(1'b1, 32'h12345678, 8'd4);
    expect_words(4);
    wait_idle(1000);
    check("t2_re_pulses", re_cnt - re0, 4);
    pop_words("t2_word", 4);

    // backpressure: six words into a depth-4 FIFO
    re0 = re_cnt;
    send_cmd(1'b0, 32'h0, 8'd6);
    expect_words(6);
    repeat (400) @(negedge clk);
    check("t3_stall_re_pulses", re_cnt - re0, 4);
    check("t3_stall_busy", bus.busy, 1);
    check("t3_stall_re_low", bus.reg_dat_re, 0);
    pop_words("t3_word", 6);
    wait_idle(500);
    check("t3_re_pulses", re_cnt - re0, 6);
    check("t3_out_empty", bus.out_valid, 0);

    // count 0 without seed: no bus activity
    re0 = re_cnt; we0 = we_cnt;
    send_cmd(1'b0, 32'h0, 8'd0);
    check("t4_busy", bus.busy, 0);
    repeat (5) @(negedge clk);
    check("t4_re", re_cnt - re0, 0);
    check("t4_we", we_cnt - we0, 0);

    // randomized commands
    for (int k = 0; k < 5; k++) begin
      en = 1'($urandom_range(0, 1));
      sd = $urandom;
      cn = 8'($urandom_range(0, 4));
      re0 = re_cnt;
      send_cmd(en, sd, cn);
      expect_words(int'(cn));
      wait_idle(1500);
      check("rnd_re_pulses", re_cnt - re0, cn);
      pop_words("rnd_word", int'(cn));
    end

    // timeout
    p_stuck = 1'b1;
    re0 = re_cnt;
    send_cmd(1'b0, 32'h0, 8'd2);
    t = 0;
    while (!bus.reg_dat_re && t < 50) begin @(negedge clk); t++; end
    check("t5_re_seen", bus.reg_dat_re, 1);
    repeat (256) @(negedge clk);
    check("t5_err_early", bus.err_timeout, 0);
    @(negedge clk);
    check("t5_err_timeout", bus.err_timeout, 1);
    check("t5_cmd_ready", bus.cmd_ready, 1);
    check("t5_busy", bus.busy, 0);
    check("t5_re_pulses", re_cnt - re0, 1);
    check("t5_out_valid", bus.out_valid, 0);
    p_stuck = 1'b0;
    @(negedge clk);
    send_cmd(1'b1, 32'hA5A5_0F0F, 8'd1);
    check("t5_err_cleared", bus.err_timeout, 0);
    expect_words(1);
    wait_idle(500);
    pop_words("t5_word", 1);

    // seed readback fault
    p_fault = 1'b1;
    re0 = re_cnt;
    send_cmd(1'b1, 32'h1, 8'd3);
    wait_idle(50);
    check("t6_err_seed", bus.err_seed, 1);
    check("t6_err_timeout", bus.err_timeout, 0);
    check("t6_re_pulses", re_cnt - re0, 0);
    p_fault = 1'b0;
    send_cmd(1'b1, 32'hCAFE_1234, 8'd1);
    check("t6_err_cleared", bus.err_seed, 0);
    expect_words(1);
    wait_idle(500);
    pop_words("t6_word", 1);

    // reset in RD_WAIT of word 2 of 5
    re0 = re_cnt;
    send_cmd(1'b1, 32'h0BAD_F00D, 8'd5);
    t = 0;
    while ((re_cnt - re0) < 2 && t < 500) begin @(negedge clk); t++; end
    check("t7_second_read", re_cnt - re0, 2);
    repeat (10) @(negedge clk);
    check("t7_busy_before", bus.busy, 1);
    #3 resetn = 1'b0;
    #1;
    check("t7_cmd_ready", bus.cmd_ready, 1);
    check("t7_busy", bus.busy, 0);
    check("t7_out_valid", bus.out_valid, 0);
    check("t7_out_data", bus.out_data, 0);
    check("t7_dat_re", bus.reg_dat_re, 0);
    check("t7_seed_we", bus.reg_seed_we, 0);
    check("t7_seed_di", bus.reg_seed_di, 0);
    check("t7_errs", {bus.err_timeout, bus.err_seed}, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    check("t7_no_more_re", re_cnt - re0, 2);
    check("t7_fifo_empty", bus.out_valid, 0);
    check("t7_idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rng_reader.md
Name: rng_reader

Overview:
- Bus initiator that drives the seeded LFSR random-word peripheral through its register interface: `reg_seed_*` and `reg_dat_*`.
- Accepts a command from upstream control logic: an optional seed load plus a word count N.
- Performs the seed write and a readback check, then issues N read transactions, honouring `reg_dat_wait`.
- Buffers the returned words in an internal FIFO, which upstream drains with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, output buffer depth in words; power of two, 2 or more.
- COUNT_W, 8, width of `cmd_count`.
- TIMEOUT, 255, maximum cycles to wait for `reg_dat_wait` to go low before aborting.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_seed_en  in  1  load `cmd_seed` before reading
- cmd_seed  in  32  seed value
- cmd_count  in  COUNT_W  number of words to read
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer pop
- out_data  out  32  FIFO head word
- busy  out  1  state is not IDLE
- err_timeout  out  1  sticky; cleared by next accepted command
- err_seed  out  1  sticky; seed readback mismatch; cleared by next accepted command
- reg_seed_we  out  4  seed byte write enables
- reg_seed_di  out  32  seed write data
- reg_seed_do  in  32  seed readback
- reg_dat_we  out  1  tied 0
- reg_dat_re  out  1  read request pulse
- reg_dat_di  out  32  tied 0
- reg_dat_do  in  32  random word
- reg_dat_wait  in  1  peripheral busy

Behaviour:
- Reset (asynchronous, `resetn`=0):
  - State goes to IDLE; FIFO is emptied.
  - All outputs are 0 except `cmd_ready`=1.
  - Reset mid-transaction abandons the transaction with no further bus activity.
- States: IDLE, SEED_WR, SEED_SETTLE, SEED_CHK, RD_REQ, RD_GAP, RD_WAIT.
- IDLE:
  - On `cmd_valid`, latch seed, enable and count; clear both error flags.
  - Next state is SEED_WR if `cmd_seed_en`=1, else RD_REQ.
  - A count of 0 without seed load returns straight to IDLE with no bus activity.
- SEED_WR (1 cycle): `reg_seed_we`=4'hF and `reg_seed_di`=seed.
- SEED_SETTLE (2 cycles): `reg_seed_we`=0. This lets the peripheral register its seed-modified flag and reload its LFSR.
- SEED_CHK (1 cycle):
  - If `reg_seed_do` differs from the seed, set `err_seed` and go to IDLE.
  - Otherwise go to RD_REQ, or IDLE if count is 0.
- RD_REQ:
  - If the FIFO has a free slot, assert `reg_dat_re` for exactly 1 cycle and go to RD_GAP.
  - If the FIFO is full, stay with `reg_dat_re`=0.
- RD_GAP (1 cycle): do not sample `reg_dat_wait`, because it may still show the stale done status of the previous read.
- RD_WAIT:
  - While `reg_dat_wait`=1, increment the timeout counter.
  - On `reg_dat_wait`=0, push `reg_dat_do` into the FIFO and decrement the remaining count. Go to RD_REQ if the count is nonzero, else IDLE.
  - If the counter reaches TIMEOUT, set `err_timeout` and go to IDLE. Already-captured words stay in the FIFO.
- Exactly one `reg_dat_re` pulse is issued per returned word, and `reg_dat_re` is never asserted outside RD_REQ.
- FIFO:
  - Standard first-word-fall-through.
  - Pop happens when `out_valid` && `out_ready`.
  - Push and pop in the same cycle while full are legal because the push is gated in RD_REQ: a read is only issued when a slot is free, so no push is ever lost.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency (peripheral of 32 shift cycles, assuming the peripheral's done indication completes on schedule): minimum RD_REQ-to-push is 35 cycles, the peripheral's 32 shift cycles plus done and the local gap.
- `cmd_valid` is ignored while busy.

Test Plan:
- Seed 0x00000000, enable=1, count=3 (a zero seed leaves the LFSR at 0) -> one `reg_seed_we`=4'hF cycle with di=0x00000000; three `reg_dat_re` pulses; `out_data` pops 0x00000000 three times; no errors; `busy` drops after the third push.
- Seed 0x12345678, count=4, compared against a bench LFSR model (taps 31, 21, 1, 0; 32 shifts per word) -> 4 words match the model in order.
- FIFO_DEPTH=4, count=6, `out_ready` held 0 -> exactly 4 `reg_dat_re` pulses, then the block stalls in RD_REQ. Raising `out_ready` yields all 6 words in order with no loss.
- Peripheral model holding `reg_dat_wait`=1 forever, TIMEOUT=255 -> `err_timeout`=1 at 255 wait cycles; IDLE; `cmd_ready`=1; a new command clears the flag.
- Seed-store fault model returning 0xDEADBEEF after a write of 0x00000001 -> `err_seed`=1 and no `reg_dat_re` is issued.
- `resetn` pulsed low in RD_WAIT of word 2 of 5 -> all outputs return to reset values immediately, the FIFO is empty, and no further `reg_dat_re` is issued.
